// File: rtl/m_rr_arbiter_2in.sv
// Two-input packet-locking round-robin arbiter driving a 2:1 flit mux select.
// A grant is held from head to tail flit; the losing input of each round gets priority next.
module m_rr_arbiter_2in #(
    parameter int P_CNT_WIDTH   = 4,
    parameter int P_MAX_PKT_LEN = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_0,
    input  logic                   req_1,
    input  logic                   tail_0,
    input  logic                   tail_1,
    input  logic                   out_ready,
    output logic                   select,
    output logic                   grant_0,
    output logic                   grant_1,
    output logic                   out_valid,
    output logic [P_CNT_WIDTH-1:0] flit_count,
    output logic                   err_overlen
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [P_CNT_WIDTH-1:0] C_CNT_SAT = {P_CNT_WIDTH{1'b1}};
    localparam logic [P_CNT_WIDTH:0]   C_MAX_LEN = (P_CNT_WIDTH + 1)'(P_MAX_PKT_LEN);

    state_e                 state_q, state_d;
    logic                   select_q, select_d;
    logic                   ptr_q, ptr_d;
    logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic                   req_sel_s;
    logic                   tail_sel_s;
    logic                   out_valid_s;
    logic                   xfer_s;
    logic [P_CNT_WIDTH:0]   cnt_inc_s;

    // Owner-side request/tail and the transfer qualifier; gated so nothing pops during reset.
    always_comb begin
        req_sel_s   = select_q ? req_1 : req_0;
        tail_sel_s  = select_q ? tail_1 : tail_0;
        cnt_inc_s   = {1'b0, cnt_q} + {{P_CNT_WIDTH{1'b0}}, 1'b1};
        out_valid_s = (state_q == ST_LOCKED) && req_sel_s && !reset;
        xfer_s      = out_valid_s && out_ready;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            select_q <= 1'b0;
            ptr_q    <= 1'b0;
            cnt_q    <= {P_CNT_WIDTH{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state: arbitrate in IDLE, count flits and release on tail in LOCKED.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_0 && req_1) begin
                    state_d  = ST_LOCKED;
                    select_d = ptr_q;
                end else if (req_0) begin
                    state_d  = ST_LOCKED;
                    select_d = 1'b0;
                end else if (req_1) begin
                    state_d  = ST_LOCKED;
                    select_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && tail_sel_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {P_CNT_WIDTH{1'b0}};
                    ptr_d   = ~select_q;
                end else if (xfer_s) begin
                    // A non-tail flit at this position means the packet cannot end legally.
                    if (cnt_inc_s >= C_MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (cnt_q != C_CNT_SAT) begin
                        cnt_d = cnt_inc_s[P_CNT_WIDTH-1:0];
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        out_valid   = out_valid_s;
        grant_0     = xfer_s && !select_q;
        grant_1     = xfer_s && select_q;
        select      = select_q;
        flit_count  = cnt_q;
        err_overlen = err_q;
    end

endmodule

// File: tb/tb_m_rr_arbiter_2in.sv
// Bench for m_rr_arbiter_2in: directed scenarios plus randomized traffic, all
// checked against a packet-level reference model (owner, pointer, flit count).
module tb_m_rr_arbiter_2in;

    localparam int MAXLEN = 8;
    localparam int CNTMAX = 15;

    logic       clk = 1'b0;
    logic       reset, req_0, req_1, tail_0, tail_1, out_ready;
    logic       select, grant_0, grant_1, out_valid, err_overlen;
    logic [3:0] flit_count;

    int checks = 0;
    int errors = 0;

    // Reference model: owner = -1 when no packet holds the output.
    int m_owner;
    bit m_sel, m_ptr, m_err;
    int m_cnt;

    m_rr_arbiter_2in #(.P_CNT_WIDTH(4), .P_MAX_PKT_LEN(MAXLEN)) dut (
        .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
        .tail_0(tail_0), .tail_1(tail_1), .out_ready(out_ready),
        .select(select), .grant_0(grant_0), .grant_1(grant_1),
        .out_valid(out_valid), .flit_count(flit_count), .err_overlen(err_overlen)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec();
        logic       ov;
        logic [3:0] c;
        ov = !reset && (m_owner >= 0) && ((m_owner == 0) ? req_0 : req_1);
        c  = m_cnt[3:0];
        return {m_sel, ov && out_ready && (m_owner == 0), ov && out_ready && (m_owner == 1),
                ov, c, m_err};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {select, grant_0, grant_1, out_valid, flit_count, err_overlen};
    endfunction

    task automatic drive(input bit rst, input bit r0, input bit r1,
                         input bit t0, input bit t1, input bit rdy);
        reset = rst; req_0 = r0; req_1 = r1; tail_0 = t0; tail_1 = t1; out_ready = rdy;
        #1;
    endtask

    // Advance the model by one clock using the currently applied inputs, then move to the next negedge.
    task automatic tick();
        bit rq, tl;
        if (reset) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (m_owner < 0) begin
            if (req_0 && req_1) m_owner = m_ptr ? 1 : 0;
            else if (req_0)     m_owner = 0;
            else if (req_1)     m_owner = 1;
            if (m_owner >= 0) m_sel = (m_owner == 1);
        end else begin
            rq = (m_owner == 1) ? req_1 : req_0;
            tl = (m_owner == 1) ? tail_1 : tail_0;
            if (rq && out_ready) begin
                if (tl) begin
                    m_owner = -1; m_cnt = 0; m_ptr = !m_sel;
                end else begin
                    if (m_cnt + 1 >= MAXLEN) m_err = 1;
                    if (m_cnt < CNTMAX) m_cnt = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 0, 1);
        tick();
        drive(1, 1, 1, 1, 1, 1);
        checks++;
        if (dut_vec() !== 9'b0) begin
            errors++;
            $display("FAIL reset_state got %b want %b", dut_vec(), 9'b0);
        end
        tick();
    endtask

    task automatic test_single_packet();
        test_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, i < 4, 0, i == 3, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_pkt cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (grant_0 !== 1'b1 || select !== 1'b0 || flit_count !== 4'(i - 1)) begin
                    errors++;
                    $display("FAIL single_pkt_flit cyc %0d got g0=%b sel=%b cnt=%0d want 1 0 %0d",
                             i, grant_0, select, flit_count, i - 1);
                end
            end
            tick();
        end
        // Pointer now favours input 1.
        drive(0, 1, 1, 1, 1, 1);
        tick();
        drive(0, 1, 1, 1, 1, 1);
        checks++;
        if (select !== 1'b1 || grant_1 !== 1'b1) begin
            errors++;
            $display("FAIL pointer_after_pkt got sel=%b g1=%b want 1 1", select, grant_1);
        end
        tick();
    endtask

    task automatic test_alternate();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 1, 1, 1);
            checks++;
            if (out_valid !== 1'(i % 2) || grant_0 !== 1'(i % 4 == 1) || grant_1 !== 1'(i % 4 == 3)
                || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL alternate cyc %0d got ov=%b g0=%b g1=%b want %0d %0d %0d",
                         i, out_valid, grant_0, grant_1, i % 2, i % 4 == 1, i % 4 == 3);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, i >= 2, i <= 6, 0, i == 6, !(i == 2 || i == 3));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            if (i >= 1 && i <= 6) begin
                checks++;
                if (select !== 1'b1 || grant_0 !== 1'b0 || grant_1 !== 1'(!(i == 2 || i == 3))) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d got sel=%b g0=%b g1=%b", i, select, grant_0, grant_1);
                end
            end
            if (i == 8) begin
                checks++;
                if (select !== 1'b0 || grant_0 !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_next_owner got sel=%b g0=%b want 0 1", select, grant_0);
                end
            end
            tick();
        end
    endtask

    task automatic test_req_drop();
        int g1 = 0;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, !(i == 2 || i == 3) && i <= 5, 0, i == 5, 1);
            g1 += int'(grant_1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL req_drop cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (out_valid !== 1'b0 || select !== 1'b1 || flit_count !== 4'd1) begin
                    errors++;
                    $display("FAIL req_drop_hold cyc %0d got ov=%b sel=%b cnt=%0d want 0 1 1",
                             i, out_valid, select, flit_count);
                end
            end
            tick();
        end
        checks++;
        if (g1 != 3) begin
            errors++;
            $display("FAIL req_drop_grants got %0d want 3", g1);
        end
    endtask

    task automatic test_overlen();
        int g0 = 0;
        test_reset();
        for (int i = 0; i < 13; i++) begin
            drive(0, i <= 9, 0, i == 9, 0, 1);
            g0 += int'(grant_0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overlen cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            checks++;
            if (err_overlen !== 1'(i >= 9)) begin
                errors++;
                $display("FAIL overlen_flag cyc %0d got %b want %0d", i, err_overlen, i >= 9);
            end
            tick();
        end
        checks++;
        if (g0 != 9) begin
            errors++;
            $display("FAIL overlen_grants got %0d want 9", g0);
        end
    endtask

    // Runs right after test_overlen so the sticky flag is set going in.
    task automatic test_reset_mid_packet();
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 0, i <= 2, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (dut_vec() !== 9'b0) begin
                    errors++;
                    $display("FAIL reset_mid_clear got %b want %b", dut_vec(), 9'b0);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit rst, r0, r1, t0, t1, rdy;
        test_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(63) == 0);
            r0  = ($urandom_range(3) != 0);
            r1  = ($urandom_range(3) != 0);
            t0  = ($urandom_range(9) == 0);
            t1  = ($urandom_range(4) == 0);
            rdy = ($urandom_range(3) != 0);
            drive(rst, r0, r1, t0, t1, rdy);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b want %b", i, dut_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_alternate();
        test_stall();
        test_req_drop();
        test_overlen();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
